cmp_event_monitor: RTL and testbench

//  Sits directly downstream of the 4-bit magnitude comparator; consumes its a_gt_b/a_eq_b/a_lt_b

---
 rtl/cmp_event_monitor.sv | 127 ++++++++++++
 tb/tb_cmp_event_monitor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cmp_event_monitor.sv
// cmp_event_monitor: debounces the one-hot relation flags of a magnitude
// comparator, commits a relation, and emits rise/fall crossing pulses with
// saturating counters. Malformed (non one-hot) samples raise flag_err.
// Optional build macro CMP_MON_STICKY_ERR_EN: flag_err is sticky until clr or
// reset. Without it, flag_err is a one-cycle pulse per malformed sample.
module cmp_event_monitor #(
  parameter int DEBOUNCE = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  input  logic             clr,
  output logic [1:0]       rel,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             flag_err
);

  // Relation encoding doubles as rank: numeric order == BELOW<EQUAL<ABOVE.
  localparam logic [1:0] UNK = 2'b00, BELOW = 2'b01, EQUAL = 2'b10, ABOVE = 2'b11;
  localparam logic [3:0] DBN = 4'(DEBOUNCE);

  logic [1:0] cand, cand_n, rel_n, s;
  logic [3:0] run, run_n;
  logic       good, bad, commit, rise_n, fall_n;

  // Decode the flag triple; candidate value UNK means "no candidate".
  always_comb begin
    s = UNK;
    case ({a_gt_b, a_eq_b, a_lt_b})
      3'b100:  s = ABOVE;
      3'b010:  s = EQUAL;
      3'b001:  s = BELOW;
      default: s = UNK;
    endcase
    good = in_valid && (s != UNK);
    bad  = in_valid && (s == UNK);
  end

  // State register: committed relation, candidate and run length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel  <= UNK;
      cand <= UNK;
      run  <= '0;
    end else begin
      rel  <= rel_n;
      cand <= cand_n;
      run  <= run_n;
    end
  end

  // Next state: only good samples move the debouncer; gaps and bad samples hold.
  always_comb begin
    rel_n  = rel;
    cand_n = cand;
    run_n  = run;
    commit = 1'b0;
    if (good) begin
      if (s == rel) begin
        cand_n = UNK;
        run_n  = '0;
      end else begin
        if (s == cand) begin
          run_n = run + 4'd1;
        end else begin
          cand_n = s;
          run_n  = 4'd1;
        end
        if (run_n >= DBN) begin
          commit = 1'b1;
          rel_n  = s;
          cand_n = UNK;
          run_n  = '0;
        end
      end
    end
  end

  // Output decode: crossing direction on a commit; leaving UNKNOWN is silent.
  always_comb begin
    rise_n = commit && (rel != UNK) && (rel_n > rel);
    fall_n = commit && (rel != UNK) && (rel_n < rel);
  end

  // Registered pulses and saturating counters; clr beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
      rise_cnt <= '0;
      fall_cnt <= '0;
    end else begin
      rise_evt <= rise_n;
      fall_evt <= fall_n;
      if (clr) begin
        rise_cnt <= '0;
        fall_cnt <= '0;
      end else begin
        if (rise_n && (rise_cnt != '1)) rise_cnt <= rise_cnt + 1'b1;
        if (fall_n && (fall_cnt != '1)) fall_cnt <= fall_cnt + 1'b1;
      end
    end
  end

`ifdef CMP_MON_STICKY_ERR_EN
  // Sticky error: a new malformed sample outranks a same-cycle clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   flag_err <= 1'b0;
    else if (bad) flag_err <= 1'b1;
    else if (clr) flag_err <= 1'b0;
  end
`else
  // Pulsed error: one cycle per malformed sample, independent of clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_err <= 1'b0;
    else        flag_err <= bad;
  end
`endif

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Directed bench: main instance (DEBOUNCE=2, CNT_W=8) and a small instance
// (DEBOUNCE=1, CNT_W=2) for saturation and clr/event collision.
module tb_cmp_event_monitor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v1 = 0, gt1 = 0, eq1 = 0, lt1 = 0, clr1 = 0;
  logic v2 = 0, gt2 = 0, eq2 = 0, lt2 = 0, clr2 = 0;
  logic [1:0] rel1, rel2;
  logic re1, fe1, re2, fe2, err1, err2;
  logic [7:0] rc1, fc1;
  logic [1:0] rc2, fc2;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  cmp_event_monitor #(.DEBOUNCE(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a_gt_b(gt1), .a_eq_b(eq1), .a_lt_b(lt1),
    .clr(clr1), .rel(rel1), .rise_evt(re1), .fall_evt(fe1), .rise_cnt(rc1), .fall_cnt(fc1),
    .flag_err(err1));

  cmp_event_monitor #(.DEBOUNCE(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2),
    .clr(clr2), .rel(rel2), .rise_evt(re2), .fall_evt(fe2), .rise_cnt(rc2), .fall_cnt(fc2),
    .flag_err(err2));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock on dut with a comparator-derived sample (or idle when vld=0).
  task automatic smp(input logic vld, input logic [3:0] a, input logic [3:0] b);
    v1 = vld; gt1 = (a > b); eq1 = (a == b); lt1 = (a < b);
    @(posedge clk); #1;
    v1 = 0;
  endtask

  task automatic raw1(input logic [2:0] f, input logic c);
    v1 = 1; {gt1, eq1, lt1} = f; clr1 = c;
    @(posedge clk); #1;
    v1 = 0; clr1 = 0;
  endtask

  task automatic raw2(input logic [2:0] f, input logic c);
    v2 = 1; {gt2, eq2, lt2} = f; clr2 = c;
    @(posedge clk); #1;
    v2 = 0; clr2 = 0;
  endtask

  initial begin
    #1;
    chk("rst_rel", rel1, 0);
    chk("rst_cnt", rc1, 0);
    chk("rst_err", err1, 0);
    @(posedge clk); #1 rst_n = 1;

    // 2: 5<7 twice -> BELOW silently, then 8>3 twice -> ABOVE with rise.
    smp(1, 5, 7); chk("t2_rel_hold", rel1, 0);
    smp(1, 5, 7); chk("t2_rel_below", rel1, 1);
    chk("t2_no_evt", {re1, fe1}, 0);
    smp(1, 8, 3); chk("t2_rel_wait", rel1, 1);
    smp(1, 8, 3); chk("t2_rel_above", rel1, 3);
    chk("t2_rise", re1, 1);
    chk("t2_rise_cnt", rc1, 1);
    smp(0, 0, 0); chk("t2_rise_1cyc", re1, 0);

    // 3: lt then gt breaks the run; lt, gaps, lt commits BELOW.
    smp(1, 1, 2); smp(1, 2, 1);
    chk("t3_rel_keep", rel1, 3);
    chk("t3_no_fall", fe1, 0);
    smp(1, 1, 2); smp(0, 0, 0); smp(0, 0, 0); smp(0, 0, 0);
    chk("t3_gap_hold", rel1, 3);
    smp(1, 1, 2); chk("t3_rel_below", rel1, 1);
    chk("t3_fall", fe1, 1);
    chk("t3_fall_cnt", fc1, 1);
    smp(0, 0, 0); chk("t3_fall_1cyc", fe1, 0);

    // 4: 9==9 twice -> EQUAL with rise; malformed 101 ignored.
    smp(1, 9, 9); smp(1, 9, 9);
    chk("t4_rel_eq", rel1, 2);
    chk("t4_rise", re1, 1);
    chk("t4_rise_cnt", rc1, 2);
    raw1(3'b101, 0);
    chk("t4_err", err1, 1);
    chk("t4_rel_keep", rel1, 2);
    smp(1, 1, 2); chk("t4_single_lt", rel1, 2);
`ifndef CMP_MON_STICKY_ERR_EN
    chk("t4_err_pulse", err1, 0);
`endif
    smp(1, 1, 2); chk("t4_second_lt", rel1, 1);
    chk("t4_fall_cnt", fc1, 2);

    // clr clears counters only.
    raw1(3'b000, 1);
    chk("clr_rise_cnt", rc1, 0);
    chk("clr_fall_cnt", fc1, 0);
    chk("clr_rel_keep", rel1, 1);

`ifdef CMP_MON_STICKY_ERR_EN
    // 6: sticky error held, cleared by clr, set beats clr.
    repeat (10) smp(0, 0, 0);
    chk("t6_sticky", err1, 1);
    raw1(3'b010, 1);
    chk("t6_clr", err1, 0);
    raw1(3'b110, 1);
    chk("t6_set_wins", err1, 1);
`else
    // Pulsed error ignores clr.
    chk("nst_all0_err", err1, 1);
    raw1(3'b110, 1);
    chk("nst_err_clr", err1, 1);
    smp(0, 0, 0);
    chk("nst_err_drop", err1, 0);
`endif

    // 5: DEBOUNCE=1, CNT_W=2: alternate lt/gt, saturate rise count.
    for (int i = 0; i < 4; i++) begin
      raw2(3'b001, 0); raw2(3'b100, 0);
    end
    chk("t5_rel", rel2, 3);
    chk("t5_rise_sat", rc2, 3);
    chk("t5_fall_cnt", fc2, 3);
    raw2(3'b001, 0);
    chk("t5_fall_sat", fc2, 3);
    raw2(3'b100, 1);
    chk("t5_clr_rise_evt", re2, 1);
    chk("t5_clr_wins", rc2, 0);

    // 1: asynchronous reset mid-run after events.
    raw1(3'b100, 0); raw1(3'b100, 0);
    chk("t1_pre_rise", re1, 1);
    #2 rst_n = 0; #1;
    chk("t1_rel", rel1, 0);
    chk("t1_rise_evt", re1, 0);
    chk("t1_cnt", rc1, 0);
    chk("t1_err", err1, 0);
    chk("t1_dut2_rel", rel2, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
